// File: rtl/pe_share_arbiter.sv
// Shares one PE between two line buffers: round-robin grant, optional per-frame lock.
// Latency: 1 cycle IDLE->BUSY arbitration; datapath and ack routing are combinational while granted.
// Backpressure: pe_ready is passed through to the owner only (to both in IDLE); the grant is released on an accepted pe_ack.
module pe_share_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_CHANNEL = 16,
    parameter int KERNEL_PTS = 9,
    parameter int LOCK_FRAME = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] lb0_data,
    input  logic                                       lb0_valid,
    input  logic                                       lb0_eof,
    output logic                                       lb0_pe_ready,
    output logic                                       lb0_pe_ack,
    input  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] lb1_data,
    input  logic                                       lb1_valid,
    input  logic                                       lb1_eof,
    output logic                                       lb1_pe_ready,
    output logic                                       lb1_pe_ack,
    output logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] pe_data,
    output logic                                       pe_valid,
    output logic                                       pe_sel,
    input  logic                                       pe_ready,
    input  logic                                       pe_ack,
    output logic [CNT_WIDTH-1:0]                       dump_win_cnt0,
    output logic [CNT_WIDTH-1:0]                       dump_win_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 sel_q, sel_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic                 grant;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        grant        = 1'b0;
        lb0_pe_ready = 1'b0;
        lb1_pe_ready = 1'b0;
        lb0_pe_ack   = 1'b0;
        lb1_pe_ack   = 1'b0;
        pe_valid     = 1'b0;
        pe_data      = sel_q ? lb1_data : lb0_data;

        case (state_q)
            IDLE: begin
                lb0_pe_ready = pe_ready;
                lb1_pe_ready = pe_ready;
                if (pe_ready && (lb0_valid || lb1_valid)) begin
                    // Contention uses rr; a lone requester wins outright and rr moves past it.
                    grant   = (lb0_valid && lb1_valid) ? rr_q : lb1_valid;
                    sel_d   = grant;
                    rr_d    = ~grant;
                    state_d = grant ? BUSY1 : BUSY0;
                end
            end
            BUSY0: begin
                lb0_pe_ready = pe_ready;
                pe_valid     = lb0_valid;
                pe_data      = lb0_data;
                lb0_pe_ack   = pe_ack && lb0_valid;
                if (pe_ack && lb0_valid) begin
                    cnt0_d = cnt0_q + CNT_WIDTH'(1);
                    if ((LOCK_FRAME == 0) || lb0_eof) begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY1: begin
                lb1_pe_ready = pe_ready;
                pe_valid     = lb1_valid;
                pe_data      = lb1_data;
                lb1_pe_ack   = pe_ack && lb1_valid;
                if (pe_ack && lb1_valid) begin
                    cnt1_d = cnt1_q + CNT_WIDTH'(1);
                    if ((LOCK_FRAME == 0) || lb1_eof) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // sel_q only changes on a grant, so pe_sel keeps the last owner through IDLE.
    assign pe_sel        = sel_q;
    assign dump_win_cnt0 = cnt0_q;
    assign dump_win_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pe_share_arbiter.sv
// Scoreboard bench: instance 0 is unlocked with 4-bit counters, instance 1 locks per frame.
module tb_pe_share_arbiter;

    localparam int W = 16;

    typedef struct packed {
        logic         sel;
        logic [W-1:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         lb_valid     [2][2];
    logic         lb_eof       [2][2];
    logic [W-1:0] lb_data      [2][2];
    logic         lb_pe_ready_o[2][2];
    logic         lb_pe_ack_o  [2][2];
    logic         pe_ready_i   [2];
    logic         pe_ack_i     [2];
    logic         pe_valid_o   [2];
    logic         pe_sel_o     [2];
    logic [W-1:0] pe_data_o    [2];
    logic [3:0]   cnt0_a, cnt1_a;
    logic [15:0]  cnt0_b, cnt1_b;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pe_share_arbiter #(
        .DATA_WIDTH(8), .IN_CHANNEL(1), .KERNEL_PTS(2), .LOCK_FRAME(0), .CNT_WIDTH(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .lb0_data(lb_data[0][0]), .lb0_valid(lb_valid[0][0]), .lb0_eof(lb_eof[0][0]),
        .lb0_pe_ready(lb_pe_ready_o[0][0]), .lb0_pe_ack(lb_pe_ack_o[0][0]),
        .lb1_data(lb_data[0][1]), .lb1_valid(lb_valid[0][1]), .lb1_eof(lb_eof[0][1]),
        .lb1_pe_ready(lb_pe_ready_o[0][1]), .lb1_pe_ack(lb_pe_ack_o[0][1]),
        .pe_data(pe_data_o[0]), .pe_valid(pe_valid_o[0]), .pe_sel(pe_sel_o[0]),
        .pe_ready(pe_ready_i[0]), .pe_ack(pe_ack_i[0]),
        .dump_win_cnt0(cnt0_a), .dump_win_cnt1(cnt1_a)
    );

    pe_share_arbiter #(
        .DATA_WIDTH(8), .IN_CHANNEL(1), .KERNEL_PTS(2), .LOCK_FRAME(1), .CNT_WIDTH(16)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .lb0_data(lb_data[1][0]), .lb0_valid(lb_valid[1][0]), .lb0_eof(lb_eof[1][0]),
        .lb0_pe_ready(lb_pe_ready_o[1][0]), .lb0_pe_ack(lb_pe_ack_o[1][0]),
        .lb1_data(lb_data[1][1]), .lb1_valid(lb_valid[1][1]), .lb1_eof(lb_eof[1][1]),
        .lb1_pe_ready(lb_pe_ready_o[1][1]), .lb1_pe_ack(lb_pe_ack_o[1][1]),
        .pe_data(pe_data_o[1]), .pe_valid(pe_valid_o[1]), .pe_sel(pe_sel_o[1]),
        .pe_ready(pe_ready_i[1]), .pe_ack(pe_ack_i[1]),
        .dump_win_cnt0(cnt0_b), .dump_win_cnt1(cnt1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] win_data(input int r, input int k);
        return W'(r * 4096 + k * 37 + 165);
    endfunction

    function automatic logic [31:0] cnt_of(input int d, input int r);
        if (d == 0) return (r == 0) ? 32'(cnt0_a) : 32'(cnt1_a);
        return (r == 0) ? 32'(cnt0_b) : 32'(cnt1_b);
    endfunction

    task automatic sb_push(input logic sel, input logic [W-1:0] data);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive_req(input int d, input int r, input int idx, input int nw, input int fr);
        lb_valid[d][r] = (idx < nw);
        lb_data[d][r]  = (idx < nw) ? win_data(r, idx) : '0;
        lb_eof[d][r]   = (idx < nw) && ((idx % fr) == (fr - 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pe_ready_i[d] = 1'b1;
            pe_ack_i[d]   = 1'b0;
            for (int r = 0; r < 2; r++) begin
                lb_valid[d][r] = 1'b0;
                lb_eof[d][r]   = 1'b0;
                lb_data[d][r]  = '0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_rdy0", lb_pe_ready_o[d][0], 1);
            check_eq("rst_rdy1", lb_pe_ready_o[d][1], 1);
            check_eq("rst_valid", pe_valid_o[d], 0);
            check_eq("rst_sel", pe_sel_o[d], 0);
            check_eq("rst_cnt0", cnt_of(d, 0), 0);
            check_eq("rst_cnt1", cnt_of(d, 1), 0);
        end
        pe_ready_i[0] = 1'b0;
        #1;
        check_eq("rst_rdy_gated", lb_pe_ready_o[0][0], 0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        pe_ready_i[0] = 1'b1;
    endtask

    // Requesters hold each window until acked; the PE acks every valid window the cycle it appears.
    task automatic run_traffic(input int d, input int n0, input int n1, input int fr0,
                               input int fr1, input int n_acks);
        int   idx[2];
        int   nw[2];
        int   fr[2];
        logic seen[2];
        int   got;
        int   cyc;
        int   s;
        exp_t e;
        idx  = '{0, 0};
        nw   = '{n0, n1};
        fr   = '{fr0, fr1};
        seen = '{1'b0, 1'b0};
        got  = 0;
        cyc  = 0;
        pe_ready_i[d] = 1'b1;
        for (int r = 0; r < 2; r++) drive_req(d, r, idx[r], nw[r], fr[r]);
        while (got < n_acks && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            pe_ack_i[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (seen[r]) begin
                    idx[r]++;
                    drive_req(d, r, idx[r], nw[r], fr[r]);
                    seen[r] = 1'b0;
                end
            end
            #1;
            if (pe_valid_o[d]) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("grant_sel", pe_sel_o[d], e.sel);
                    check_eq("grant_data", pe_data_o[d], e.data);
                end
                pe_ack_i[d] = 1'b1;
                #1;
                s       = int'(pe_sel_o[d]);
                seen[0] = lb_pe_ack_o[d][0];
                seen[1] = lb_pe_ack_o[d][1];
                check_eq("ack_owner", lb_pe_ack_o[d][s], 1);
                check_eq("ack_other", lb_pe_ack_o[d][1-s], 0);
                got++;
            end
        end
        if (got < n_acks) check_eq("traffic_timeout", got, n_acks);
        @(posedge clk);
        #1;
        pe_ack_i[d] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (seen[r]) begin
                idx[r]++;
                drive_req(d, r, idx[r], nw[r], fr[r]);
            end
        end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        do_reset();

        // Single requester on the unlocked instance
        lb_valid[0][0] = 1'b1;
        lb_data[0][0]  = 16'h1234;
        sb_push(1'b0, 16'h1234);
        #1;
        check_eq("idle_no_valid", pe_valid_o[0], 0);
        @(posedge clk);
        #1;
        check_eq("single_valid", pe_valid_o[0], 1);
        check_eq("single_rdy_other", lb_pe_ready_o[0][1], 0);
        e = sb.pop_front();
        check_eq("single_sel", pe_sel_o[0], e.sel);
        check_eq("single_data", pe_data_o[0], e.data);
        pe_ack_i[0] = 1'b1;
        #1;
        check_eq("single_ack0", lb_pe_ack_o[0][0], 1);
        check_eq("single_ack1", lb_pe_ack_o[0][1], 0);
        @(posedge clk);
        #1;
        pe_ack_i[0]    = 1'b0;
        lb_valid[0][0] = 1'b0;
        #1;
        check_eq("single_cnt0", cnt0_a, 1);
        check_eq("single_idle", pe_valid_o[0], 0);
        check_eq("single_idle_rdy1", lb_pe_ready_o[0][1], 1);
        check_eq("single_sel_hold", pe_sel_o[0], 0);

        // Contention, unlocked: grants alternate starting at requester 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            sb_push(1'b0, win_data(0, k));
            sb_push(1'b1, win_data(1, k));
        end
        run_traffic(0, 3, 3, 1, 1, 6);
        check_eq("rr_cnt0", cnt0_a, 3);
        check_eq("rr_cnt1", cnt1_a, 3);
        check_eq("rr_sb_empty", sb.size(), 0);

        // Frame lock: four windows of lb0 before lb1 gets the PE
        for (int k = 0; k < 4; k++) sb_push(1'b0, win_data(0, k));
        sb_push(1'b1, win_data(1, 0));
        run_traffic(1, 4, 1, 4, 1, 5);
        check_eq("lock_cnt0", cnt0_b, 4);
        check_eq("lock_cnt1", cnt1_b, 1);
        check_eq("lock_sb_empty", sb.size(), 0);

        // Lone requester 1 on instance 0, then valid drop and spurious ack
        pe_ready_i[0]  = 1'b1;
        lb_valid[0][1] = 1'b1;
        lb_data[0][1]  = win_data(1, 9);
        @(posedge clk);
        #1;
        check_eq("b1_sel", pe_sel_o[0], 1);
        check_eq("b1_valid", pe_valid_o[0], 1);
        check_eq("b1_rdy0", lb_pe_ready_o[0][0], 0);
        lb_valid[0][1] = 1'b0;
        #1;
        check_eq("drop_valid", pe_valid_o[0], 0);
        pe_ack_i[0] = 1'b1;
        #1;
        check_eq("spur_ack1", lb_pe_ack_o[0][1], 0);
        check_eq("spur_ack0", lb_pe_ack_o[0][0], 0);
        @(posedge clk);
        #1;
        pe_ack_i[0] = 1'b0;
        #1;
        check_eq("spur_cnt1", cnt1_a, 3);
        check_eq("spur_still_b1", lb_pe_ready_o[0][0], 0);
        check_eq("spur_rdy1", lb_pe_ready_o[0][1], 1);
        lb_valid[0][1] = 1'b1;
        #1;
        check_eq("regrant_valid", pe_valid_o[0], 1);

        // Asynchronous reset while BUSY1 with an ack pending
        lb_valid[0][0] = 1'b1;
        lb_data[0][0]  = win_data(0, 7);
        pe_ack_i[0]    = 1'b1;
        rst_n          = 1'b0;
        #1;
        check_eq("mid_rst_ack1", lb_pe_ack_o[0][1], 0);
        check_eq("mid_rst_valid", pe_valid_o[0], 0);
        check_eq("mid_rst_rdy0", lb_pe_ready_o[0][0], 1);
        check_eq("mid_rst_sel", pe_sel_o[0], 0);
        check_eq("mid_rst_cnt0", cnt0_a, 0);
        check_eq("mid_rst_cnt1", cnt1_a, 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        pe_ack_i[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_sel", pe_sel_o[0], 0);
        check_eq("post_rst_valid", pe_valid_o[0], 1);
        check_eq("post_rst_data", pe_data_o[0], win_data(0, 7));

        // 4-bit counter wrap: 17 acks on requester 1
        do_reset();
        for (int k = 0; k < 17; k++) sb_push(1'b1, win_data(1, k));
        run_traffic(0, 0, 17, 1, 1, 17);
        check_eq("wrap_cnt1", cnt1_a, 1);
        check_eq("wrap_cnt0", cnt0_a, 0);
        check_eq("wrap_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_share_arbiter.md
PE_SHARE_ARBITER -- requirements
Module: pe_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per channel sample.
REQ-002 SHALL have parameter IN_CHANNEL, default 16, channels per pixel.
REQ-003 SHALL have parameter KERNEL_PTS, default 9, window points; W = DATA_WIDTH*IN_CHANNEL*KERNEL_PTS.
REQ-004 SHALL have parameter LOCK_FRAME, default 0; 1 = hold grant for a whole frame.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of window counters.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 lb0_data  input  W  window from line buffer 0.
REQ-009 lb0_valid  input  1  window 0 valid; held with data stable until acked.
REQ-010 lb0_eof  input  1  window 0 is the last window of its frame.
REQ-011 lb0_pe_ready  output  1  PE-ready view presented to line buffer 0.
REQ-012 lb0_pe_ack  output  1  PE acknowledge routed to line buffer 0.
REQ-013 lb1_data, lb1_valid, lb1_eof, lb1_pe_ready, lb1_pe_ack: same as REQ-008..012 for line buffer 1.
REQ-014 pe_data  output  W  window presented to the shared PE.
REQ-015 pe_valid  output  1  pe_data valid.
REQ-016 pe_sel  output  1  owner of current transfer (0/1); PE uses it for weight/bias bank select.
REQ-017 pe_ready  input  1  PE can accept a window.
REQ-018 pe_ack  input  1  PE consumed pe_data (one-cycle pulse).
REQ-019 dump_win_cnt0, dump_win_cnt1  output  CNT_WIDTH  acked-window counts per requester.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY0, BUSY1; grant register g = 0 in BUSY0, 1 in BUSY1.
REQ-021 IDLE: lb0_pe_ready = lb1_pe_ready = pe_ready; pe_valid = 0; pe_ack not routed.
REQ-022 BUSYx: lbx_pe_ready = pe_ready, other requester's pe_ready = 0.
REQ-023 IDLE -> BUSYx when pe_ready=1 and lbx_valid=1; grant takes effect next cycle (1-cycle arbitration latency).
REQ-024 Both valid in same IDLE cycle: grant to requester indicated by round-robin pointer rr (reset 0); rr toggles to the other requester after each completed grant period.
REQ-025 Only one valid: grant to it regardless of rr; rr then points to the other requester.
REQ-026 BUSYx datapath is combinational: pe_data = lbx_data, pe_valid = lbx_valid, pe_sel = g.
REQ-027 pe_sel SHALL hold last grant in IDLE (no glitch to 0).
REQ-028 lbx_pe_ack = pe_ack AND state==BUSYx AND lbx_valid; other requester's ack = 0.
REQ-029 pe_ack while pe_valid=0 SHALL be ignored: no counter change, no state change.
REQ-030 LOCK_FRAME=0: accepted pe_ack in BUSYx -> IDLE next cycle.
REQ-031 LOCK_FRAME=1: accepted pe_ack in BUSYx stays BUSYx unless lbx_eof=1 in the ack cycle, then -> IDLE.
REQ-032 lbx_valid dropping before ack (protocol violation) SHALL NOT release grant; pe_valid follows lbx_valid.
REQ-033 dump_win_cntx SHALL increment by 1 on each accepted ack for requester x; wraps modulo 2^CNT_WIDTH.
REQ-034 Back-to-back: minimum one IDLE cycle between grants when LOCK_FRAME=0 (max throughput 1 window per 2 cycles plus PE latency).

Reset
REQ-035 rst_n low SHALL asynchronously force state IDLE, rr=0, pe_sel=0, counters=0; pe_valid, lbx_pe_ack = 0.
REQ-036 Reset mid-transfer SHALL drop grant immediately; no ack forwarded; first post-reset grant follows REQ-023..025.
REQ-037 lbx_pe_ready during reset SHALL equal pe_ready gated as IDLE.

Verification
REQ-038 Single requester: lb0_valid=1, pe_ready=1 -> BUSY0 after 1 cycle, pe_sel=0, pe_data=lb0_data; pe_ack -> lb0_pe_ack=1, cnt0=1, IDLE next cycle.
REQ-039 Contention, LOCK_FRAME=0: both valid continuously, 6 acks -> grants alternate 0,1,0,1,0,1; cnt0=cnt1=3; lb1_pe_ack never 1 during BUSY0.
REQ-040 LOCK_FRAME=1: lb0 frame of 4 windows (eof on 4th) with lb1 valid throughout -> 4 consecutive grants to 0, then BUSY1.
REQ-041 Spurious ack: pe_ack with pe_valid=0 in BUSY1 -> no ack routed, cnt1 unchanged, stays BUSY1.
REQ-042 Reset mid-BUSY1 (rst_n low 1 cycle) -> IDLE, counters 0, rr=0; both valid after -> grant to 0.
REQ-043 Counter wrap with CNT_WIDTH=4: 17 acks on requester 1 -> dump_win_cnt1=1.
